// File: rtl/joy_dir_filter_if.sv
// joy_dir_filter_if: config and direction bundle for joy_dir_filter.
// master drives mode/rotate/indir; slave returns outdir/changed.
interface joy_dir_filter_if #(
  parameter int PLAYERS = 2
) ();
  logic [1:0]           mode;
  logic [1:0]           rotate;
  logic [4*PLAYERS-1:0] indir;
  logic [4*PLAYERS-1:0] outdir;
  logic [PLAYERS-1:0]   changed;

  modport master (
    output mode,
    output rotate,
    output indir,
    input  outdir,
    input  changed
  );

  modport slave (
    input  mode,
    input  rotate,
    input  indir,
    output outdir,
    output changed
  );
endinterface

// File: rtl/joy_dir_filter.sv
// joy_dir_filter: per-player debounce, rotate, 8/4/2-way restrict.
// Ports: clk, reset_n (async low), bus (slave: mode/rotate/indir in, outdir/changed out).
module joy_dir_filter #(
  parameter int PLAYERS   = 2,
  parameter int DB_W      = 4,
  parameter int DB_CYCLES = 8
) (
  input logic             clk,
  input logic             reset_n,
  joy_dir_filter_if.slave bus
);

  localparam int N = 4 * PLAYERS;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [N-1:0]       s_in;
  logic [N-1:0]       db;
  logic [1:0]         mode_q;
  logic [1:0]         rot_q;
  logic               cfg_chg;
  logic [N-1:0]       out_all;
  logic [PLAYERS-1:0] chg_all;

  // {U,D,L,R}; rotation is clockwise in quarter turns
  function automatic logic [3:0] rot4(
    input logic [3:0] x,
    input logic [1:0] r
  );
    logic [3:0] y;
    y = x;
    unique case (r)
      2'd0: y = x;
      2'd1: y = {x[1], x[0], x[2], x[3]};
      2'd2: y = {x[2], x[3], x[0], x[1]};
      2'd3: y = {x[0], x[1], x[3], x[2]};
    endcase
    return y;
  endfunction

  function automatic logic [3:0] cancel(
    input logic [3:0] x
  );
    logic [3:0] y;
    y = x;
    if (x[3] && x[2]) y[3:2] = 2'b00;
    if (x[1] && x[0]) y[1:0] = 2'b00;
    return y;
  endfunction

  // U > D > L > R
  function automatic logic [3:0] pick(
    input logic [3:0] x
  );
    logic [3:0] y;
    y = 4'b0000;
    if (x[3])      y = 4'b1000;
    else if (x[2]) y = 4'b0100;
    else if (x[1]) y = 4'b0010;
    else if (x[0]) y = 4'b0001;
    return y;
  endfunction

  assign cfg_chg = (bus.mode != mode_q)
                 || (bus.rotate != rot_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_in   <= '0;
      mode_q <= 2'd0;
      rot_q  <= 2'd0;
    end else begin
      s_in   <= bus.indir;
      mode_q <= bus.mode;
      rot_q  <= bus.rotate;
    end
  end

  if (DB_CYCLES == 0) begin : g_nodb
    assign db = s_in;
  end else begin : g_db
    localparam logic [DB_W-1:0] DB_LIM = DB_W'(DB_CYCLES);
    localparam logic [DB_W-1:0] ONE    = DB_W'(1);

    logic [DB_W-1:0] cnt [N];
    logic [N-1:0]    db_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        db_q <= '0;
        for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (s_in[i] == db_q[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] + ONE == DB_LIM) begin
            db_q[i] <= s_in[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + ONE;
          end
        end
      end
    end

    assign db = db_q;
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    logic [3:0] v;
    logic [3:0] v_prev;
    logic [3:0] nw;
    logic [0:0] st;
    logic [0:0] st_nxt;
    logic [3:0] hd;
    logic [3:0] hd_nxt;
    logic [3:0] out_q;
    logic [3:0] out_nxt;
    logic       chg_q;

    assign v  = cancel(rot4(db[4*p +: 4], bus.rotate));
    assign nw = v & ~v_prev;

    always_comb begin
      st_nxt = st;
      hd_nxt = hd;
      if (st == ST_IDLE || (v & hd) == 4'b0000) begin
        // idle, or the held direction was just released
        if (v != 4'b0000) begin
          st_nxt = ST_HOLD;
          hd_nxt = pick(v);
        end else begin
          st_nxt = ST_IDLE;
          hd_nxt = 4'b0000;
        end
      end else if (bus.mode == 2'd1 && nw != 4'b0000) begin
        hd_nxt = pick(nw);
      end
      if (cfg_chg) begin
        st_nxt = ST_IDLE;
        hd_nxt = 4'b0000;
      end
    end

    always_comb begin
      out_nxt = 4'b0000;
      unique case (bus.mode)
        2'd0: out_nxt = v;
        2'd1,
        2'd2: out_nxt = (st_nxt == ST_HOLD) ? hd_nxt : 4'b0000;
        2'd3: out_nxt = {2'b00, v[1:0]};
      endcase
      if (cfg_chg) out_nxt = 4'b0000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st     <= ST_IDLE;
        hd     <= 4'b0000;
        v_prev <= 4'b0000;
        out_q  <= 4'b0000;
        chg_q  <= 1'b0;
      end else begin
        st     <= st_nxt;
        hd     <= hd_nxt;
        v_prev <= cfg_chg ? 4'b0000 : v;
        out_q  <= out_nxt;
        chg_q  <= (out_nxt != out_q);
      end
    end

    assign out_all[4*p +: 4] = out_q;
    assign chg_all[p]        = chg_q;
  end

  assign bus.outdir  = out_all;
  assign bus.changed = chg_all;

endmodule

// File: doc/joy_dir_filter.md
Name: joy_dir_filter

Overview:
- Multi-player joystick direction conditioner between the raw joystick mux (USB/DB9/DB15) and the arcade core's input ports.
- Per player it debounces, rotates to match screen orientation, and restricts to 8-way, 4-way last-pressed, 4-way first-held or 2-way horizontal movement.
- Replaces per-game one-direction filtering with a single parametrised, runtime-selectable block.

Parameters:
- PLAYERS, 2, number of independent channels (1..4).
- DB_W, 4, debounce counter width in bits.
- DB_CYCLES, 8, consecutive stable cycles needed to accept a change; 0 = debounce bypass; must be < 2^DB_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  2  0=8-way, 1=4-way last-pressed, 2=4-way first-held, 3=2-way horizontal.
- rotate  in  2  0=none, 1=90 CW, 2=180, 3=270 CW.
- indir  in  4*PLAYERS  raw directions; player p at [4p+3:4p] = {up,down,left,right}, active-high.
- outdir  out  4*PLAYERS  filtered directions, same packing, registered.
- changed  out  PLAYERS  1-cycle pulse when that player's outdir value changes.

Behaviour:
- Reset (async assert, sync release): outdir=0, changed=0, sample regs=0, debounced=0, counters=0, arbiters IDLE, mode/rotate shadow regs = 0.
- Stage 1: indir registered into s_in each cycle.
- Debounce, per bit:
  - if s_in != db, counter increments; when it reaches DB_CYCLES, db <= s_in and counter <= 0.
  - if s_in == db, counter <= 0.
  - DB_CYCLES=0: db = s_in combinationally, no register.
- Rotation (combinational on db), output {U,D,L,R}:
  - 90 CW: U<-L, R<-U, D<-R, L<-D.
  - 180: U<->D, L<->R.
  - 270: inverse of 90.
- Opposite cancel (all modes): U&D both set clears both; L&R both set clears both. Applied after rotation, giving vector v.
- Mode 0: out <= v.
- Mode 3: out <= {2'b00, v[1:0]}.
- Modes 1/2, per-channel arbiter with states IDLE and HOLD(d), d one-hot:
  - new = v & ~v_prev (v_prev registered). Priority for simultaneous new or remaining presses: U > D > L > R.
  - IDLE: if v != 0, go to HOLD(highest-priority bit of v).
  - HOLD(d), mode 1: if new != 0, go to HOLD(highest-priority new), even when d is still held.
  - HOLD(d), mode 2: new presses are ignored while d is held.
  - HOLD(d), both modes, d released: if v != 0 go to HOLD(highest-priority bit of v), else IDLE. Same cycle.
  - out <= d in HOLD, 0 in IDLE. At most one bit set in 4-way modes.
- Latency, raw edge to outdir: 2 cycles when DB_CYCLES=0; 2+DB_CYCLES cycles otherwise.
- changed[p] <= (next outdir_p != outdir_p). Registered alongside outdir.
- Runtime change:
  - mode/rotate are shadow-registered; any difference from the shadow is a config change.
  - On the cycle a config change is detected: all arbiters go IDLE, v_prev is cleared, and every outdir is forced 0 (changed pulses if outdir was nonzero). Normal operation resumes the next cycle.
  - Debounce state is unaffected.
- Channels are fully independent; no cross-player interaction.
- Reset asserted mid-hold: outputs go to 0 immediately. No changed pulse on reset.

Test Plan:
- DB_CYCLES=0, mode 0, rotate 0: P0 indir=4'b1010 at cycle 10 -> outdir[3:0]=4'b1010 at cycle 12, changed[0]=1 at cycle 12 only.
- DB_CYCLES=8: P0 up bit glitches high for 5 cycles -> outdir stays 0. Held for 12 cycles -> outdir=4'b1000 exactly 10 cycles after the raw edge.
- Mode 1: hold up, then add right -> out 4'b0001. Release right -> out 4'b1000. Release up -> 0. Up and left pressed the same cycle -> 4'b1000.
- Mode 2: hold left, add down -> stays 4'b0010. Release left -> 4'b0100.
- rotate=1, mode 0: input left 4'b0010 -> out up 4'b1000. Input U+D 4'b1100 -> out 0. Mode 3 with input 4'b1001 -> 4'b0001.
- Switch mode 1->0 while holding right: outdir 0 for exactly 1 cycle with a changed pulse, then 4'b0001. Assert reset_n=0 mid-hold -> outdir=0 asynchronously, channel P1 unaffected until reset.
